// File: rtl/md_unit.sv
// md_unit: multi-cycle MIPS multiply/divide unit holding the architectural HI/LO registers
module md_unit #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        start,
  input  logic [2:0]  md_op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic        busy,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);
  typedef enum logic {IDLE, RUN} state_t;
  state_t      r_state, w_state_nx;
  logic [3:0]  r_cnt, w_cnt_nx;
  logic [1:0]  r_op, w_op_nx;
  logic [31:0] r_a, r_b, r_hi, r_lo, w_a_nx, w_b_nx, w_hi_nx, w_lo_nx;
  logic        r_done, w_done_nx;
  logic [63:0] w_prod, w_res;
  logic        w_neg_a, w_neg_b;
  logic [31:0] w_abs_a, w_abs_b, w_div_b, w_quo, w_rem;
  // Signed divide works on magnitudes so 0x80000000 / -1 wraps naturally to 0x80000000
  assign w_prod  = r_op[0] ? {32'b0, r_a} * {32'b0, r_b}
                           : {{32{r_a[31]}}, r_a} * {{32{r_b[31]}}, r_b};
  assign w_neg_a = ~r_op[0] & r_a[31];
  assign w_neg_b = ~r_op[0] & r_b[31];
  assign w_abs_a = w_neg_a ? -r_a : r_a;
  assign w_abs_b = w_neg_b ? -r_b : r_b;
  assign w_div_b = (r_b == 32'd0) ? 32'd1 : w_abs_b;
  assign w_quo   = w_abs_a / w_div_b;
  assign w_rem   = w_abs_a % w_div_b;
  assign w_res   = r_op[1] ? {w_neg_a ? -w_rem : w_rem, (w_neg_a ^ w_neg_b) ? -w_quo : w_quo}
                           : w_prod;
  always_comb begin
    w_state_nx = r_state;
    w_cnt_nx   = r_cnt;
    w_op_nx    = r_op;
    w_a_nx     = r_a;
    w_b_nx     = r_b;
    w_hi_nx    = r_hi;
    w_lo_nx    = r_lo;
    w_done_nx  = 1'b0;
    if (r_state == IDLE && start) begin
      if (!md_op[2]) begin
        w_state_nx = RUN;
        w_op_nx    = md_op[1:0];
        w_a_nx     = src_a;
        w_b_nx     = src_b;
        w_cnt_nx   = md_op[1] ? 4'(DIV_CYCLES) : 4'(MULT_CYCLES);
      end else if (md_op[1:0] == 2'd0) begin
        w_hi_nx = src_a;
      end else if (md_op[1:0] == 2'd1) begin
        w_lo_nx = src_a;
      end
    end else if (r_state == RUN) begin
      w_cnt_nx = r_cnt - 4'd1;
      if (r_cnt == 4'd1) begin
        w_state_nx = IDLE;
        w_done_nx  = 1'b1;
        if (!(r_op[1] && r_b == 32'd0)) {w_hi_nx, w_lo_nx} = w_res;
      end
    end
  end
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= IDLE;
      r_cnt   <= '0;
      r_op    <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_hi    <= '0;
      r_lo    <= '0;
      r_done  <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      r_cnt   <= w_cnt_nx;
      r_op    <= w_op_nx;
      r_a     <= w_a_nx;
      r_b     <= w_b_nx;
      r_hi    <= w_hi_nx;
      r_lo    <= w_lo_nx;
      r_done  <= w_done_nx;
    end
  end
  assign busy = (r_state == RUN);
  assign done = r_done;
  assign hi   = r_hi;
  assign lo   = r_lo;
endmodule

// File: tb/tb_md_unit.sv
// tb_md_unit: directed scoreboard bench for md_unit
module tb_md_unit;
  logic        clk = 1'b0;
  logic        reset_n;
  logic        start;
  logic [2:0]  md_op;
  logic [31:0] src_a, src_b;
  logic        busy, done;
  logic [31:0] hi, lo;
  int          checks = 0;
  int          passed = 0;
  int          done_seen;
  logic [31:0] m_hi, m_lo;
  logic [63:0] sb_q[$];

  md_unit dut (
    .clk(clk), .reset_n(reset_n), .start(start), .md_op(md_op),
    .src_a(src_a), .src_b(src_b), .busy(busy), .done(done), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [63:0] model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    longint sa, sb, q, r;
    logic [63:0] ua, ub, uq, ur;
    sa = longint'($signed(a));
    sb = longint'($signed(b));
    ua = {32'b0, a};
    ub = {32'b0, b};
    if (op == 3'd0) return 64'(sa * sb);
    if (op == 3'd1) return ua * ub;
    if (b == 32'd0) return {m_hi, m_lo};
    if (op == 3'd2) begin
      q = sa / sb;
      r = sa % sb;
      return {r[31:0], q[31:0]};
    end
    uq = ua / ub;
    ur = ua % ub;
    return {ur[31:0], uq[31:0]};
  endfunction

  task automatic issue(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    logic [63:0] e;
    start = 1'b1;
    md_op = op;
    src_a = a;
    src_b = b;
    if (op < 3'd4) begin
      e = model(op, a, b);
      sb_q.push_back(e);
      {m_hi, m_lo} = e;
    end else if (op == 3'd4) m_hi = a;
    else if (op == 3'd5) m_lo = a;
    step();
    start = 1'b0;
  endtask

  task automatic wait_done(input string tag, input int n_exp, input int pre);
    int n;
    logic [63:0] e;
    n = pre;
    while (busy && n < 40) begin
      n++;
      step();
    end
    check({tag, "_busy_cycles"}, 64'(n), 64'(n_exp));
    check({tag, "_done"}, 64'(done), 64'd1);
    check({tag, "_sb_nonempty"}, 64'(sb_q.size() > 0), 64'd1);
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      check({tag, "_hilo"}, {hi, lo}, e);
    end
  endtask

  initial begin
    reset_n = 1'b0;
    start   = 1'b0;
    md_op   = 3'd6;
    src_a   = '0;
    src_b   = '0;
    m_hi    = '0;
    m_lo    = '0;
    #12;
    check("reset_state", {30'b0, busy, done, hi, lo}, 64'd0);
    reset_n = 1'b1;
    step();
    issue(3'd0, 32'hFFFF_FFFF, 32'd2);
    wait_done("mult", 5, 0);
    step();
    check("mult_done_fall", 64'(done), 64'd0);
    issue(3'd1, 32'hFFFF_FFFF, 32'd2);
    wait_done("multu", 5, 0);
    check("multu_val", {hi, lo}, 64'h0000_0001_FFFF_FFFE);
    step();
    issue(3'd2, 32'hFFFF_FFF9, 32'd2);
    wait_done("div", 10, 0);
    check("div_val", {hi, lo}, 64'hFFFF_FFFF_FFFF_FFFD);
    step();
    issue(3'd3, 32'd7, 32'd2);
    wait_done("divu", 10, 0);
    step();
    issue(3'd2, 32'h8000_0000, 32'hFFFF_FFFF);
    wait_done("div_ovf", 10, 0);
    check("div_ovf_val", {hi, lo}, 64'h0000_0000_8000_0000);
    step();
    issue(3'd3, 32'd5, 32'd0);
    wait_done("divu_zero", 10, 0);
    check("divu_zero_val", {hi, lo}, 64'h0000_0000_8000_0000);
    step();
    issue(3'd0, 32'h0001_0001, 32'h0002_0003);
    start = 1'b1;
    md_op = 3'd4;
    src_a = 32'h1234_5678;
    step();
    check("mthi_ignored", 64'(hi), 64'h0);
    md_op = 3'd2;
    src_a = 32'd9;
    src_b = 32'd3;
    step();
    start = 1'b0;
    wait_done("mult_ign", 5, 2);
    step();
    check("no_extra_run", 64'(busy), 64'd0);
    issue(3'd5, 32'hCAFE_F00D, 32'd0);
    check("mtlo_val", {m_hi, lo}, {m_hi, 32'hCAFE_F00D});
    check("mtlo_flags", {62'b0, busy, done}, 64'd0);
    issue(3'd4, 32'hDEAD_BEEF, 32'd0);
    check("mthi_val", {hi, lo}, {32'hDEAD_BEEF, 32'hCAFE_F00D});
    issue(3'd0, 32'd3, 32'd4);
    wait_done("b2b_mult", 5, 0);
    check("b2b_mult_lo", 64'(lo), 64'd12);
    issue(3'd3, 32'd100, 32'd7);
    check("b2b_done_fall", {62'b0, busy, done}, 64'd2);
    src_a = 32'hAAAA_AAAA;
    src_b = 32'd0;
    wait_done("b2b_divu", 10, 0);
    check("b2b_divu_val", {hi, lo}, {32'd2, 32'd14});
    step();
    issue(3'd2, 32'd100, 32'd3);
    step();
    step();
    #2;
    reset_n = 1'b0;
    #1;
    check("async_reset", {30'b0, busy, done, hi, lo}, 64'd0);
    sb_q.delete();
    m_hi = '0;
    m_lo = '0;
    step();
    #2;
    reset_n = 1'b1;
    done_seen = 0;
    for (int i = 0; i < 12; i++) begin
      step();
      if (done || busy) done_seen++;
    end
    check("no_done_after_reset", 64'(done_seen), 64'd0);
    check("hilo_after_reset", {hi, lo}, 64'd0);
    #2;
    reset_n = 1'b0;
    #1;
    reset_n = 1'b1;
    issue(3'd0, 32'hFFFF_FFF9, 32'd6);
    wait_done("post_reset_mult", 5, 0);
    step();
    check("post_reset_done_fall", 64'(done), 64'd0);
    $display("%0d/%0d checks passed", passed, checks);
    $finish;
  end
endmodule

// File: doc/md_unit.md
# md_unit

Multi-cycle multiply/divide unit for the MIPS datapath. It sits downstream of the ALU operand mux and consumes the same operand pair as the ALU: `src_a` from GRF read port 1 and `src_b` from the ALU B-operand mux output. It executes MULT/MULTU/DIV/DIVU over a fixed cycle count, services MTHI/MTLO in one cycle, and holds the architectural HI/LO registers that the MFHI/MFLO path reads.

## Interface

Parameters:
- `MULT_CYCLES`, default 5. Busy cycles for MULT/MULTU; legal range 1..15.
- `DIV_CYCLES`, default 10. Busy cycles for DIV/DIVU; legal range 1..15.

Ports:
- `clk`, input, 1 bit. Single clock; all state changes on the rising edge.
- `reset_n`, input, 1 bit. Asynchronous, active-low reset.
- `start`, input, 1 bit. Qualifies `md_op` for one cycle.
- `md_op`, input, 3 bits. 0 = MULT, 1 = MULTU, 2 = DIV, 3 = DIVU, 4 = MTHI, 5 = MTLO, 6 and 7 = no-op.
- `src_a`, input, 32 bits. rs operand; dividend or multiplicand.
- `src_b`, input, 32 bits. Output of the ALU B-operand mux; divisor or multiplier.
- `busy`, output, 1 bit. High while a MULT or DIV operation is in flight.
- `done`, output, 1 bit. One-cycle pulse in the cycle after a MULT or DIV result commits.
- `hi`, output, 32 bits. Architectural HI register.
- `lo`, output, 32 bits. Architectural LO register.

## Operation

States:
- IDLE.
- RUN, with a 4-bit down-counter `cnt` and a latched operation class.

Reset:
- `reset_n` low forces IDLE, `cnt` = 0, `busy` = 0, `done` = 0, `hi` = 0, `lo` = 0.
- These take effect immediately, asynchronously.

In IDLE, when `start` is high:
- `md_op` 0–3: latch `src_a`, `src_b` and the op; load `cnt` with MULT_CYCLES or DIV_CYCLES; enter RUN.
- `md_op` 4: `hi` <= `src_a`; stay in IDLE.
- `md_op` 5: `lo` <= `src_a`; stay in IDLE.
- `md_op` 6–7: no state change.

In RUN:
- `cnt` decrements each cycle.
- `start` is ignored entirely, including MTHI/MTLO.
- `hi` and `lo` hold their old values.
- When `cnt` reaches 1, the next edge commits the result, returns to IDLE, and sets `done` = 1 for one cycle.

Arithmetic (operands are those latched at start, not the live inputs):
- MULT: {hi, lo} = signed 64-bit product.
- MULTU: {hi, lo} = unsigned 64-bit product.
- DIV: lo = quotient truncated toward zero; hi = remainder, which takes the sign of the dividend.
- DIV 0x80000000 / 0xFFFFFFFF: lo = 0x80000000, hi = 0.
- DIVU: lo = unsigned quotient; hi = unsigned remainder.
- Divisor 0, DIV or DIVU: runs the full DIV_CYCLES with `busy` high; `hi` and `lo` are left unchanged; `done` still pulses.

The implementation may compute results combinationally at latch time or iteratively. Only commit timing and values are observable.

## Timing

- `start` sampled at edge E0 with op 0–3: `busy` = 1 from E0 through E0+N, where N = MULT_CYCLES or DIV_CYCLES. `busy` is high for exactly N cycles.
- At edge E0+N: `hi`/`lo` update, `busy` falls, `done` rises.
- `done` falls at E0+N+1.
- `start` may be asserted in the cycle where `done` is high, since `busy` is already low; it is accepted normally.
- MTHI/MTLO: the new value is visible on `hi`/`lo` after the sampling edge (1-cycle latency). `busy` and `done` never assert.
- Upstream stall contract: the hazard unit stalls any MD-class or MFHI/MFLO instruction while `busy` = 1 or while `start` = 1 with op 0–3. The block itself adds no stall logic.
- Reset asserted mid-RUN:
  - The operation is abandoned; no commit and no `done` pulse afterwards.
  - After `reset_n` rises, the block is in IDLE and accepts `start` on the first edge.

## Test plan

1. MULT, `src_a` = 0xFFFFFFFF, `src_b` = 2 → `busy` high for 5 cycles, then hi = 0xFFFFFFFF, lo = 0xFFFFFFFE, `done` pulses once. Repeat as MULTU → hi = 0x00000001, lo = 0xFFFFFFFE.
2. DIV, 0xFFFFFFF9 / 2 → after 10 busy cycles, lo = 0xFFFFFFFD, hi = 0xFFFFFFFF. DIVU, 7 / 2 → lo = 3, hi = 1.
3. Overflow and divide-by-zero:
   - DIV 0x80000000 / 0xFFFFFFFF → lo = 0x80000000, hi = 0.
   - Then DIVU 5 / 0 → 10 busy cycles, `done` pulses, hi/lo still 0 and 0x80000000.
4. Ignored inputs while busy:
   - During MULT, assert `start` with MTHI 0x12345678 and with DIV → both ignored; final hi/lo equal the MULT result.
   - Then, idle, MTLO 0xCAFEF00D → lo = 0xCAFEF00D on the next edge; `busy` never rises.
5. Back-to-back: MULT 3 × 4, then `start` DIVU 100 / 7 in the `done` cycle → lo = 12 first, then lo = 14, hi = 2 after 10 more cycles. Also change `src_a`/`src_b` during RUN; the result must be unaffected.
6. Reset mid-operation: pull `reset_n` low between clock edges in busy cycle 3 of a DIV → `busy`, `done`, `hi`, `lo` go to 0 without waiting for an edge. No `done` pulse after release. A MULT started on the first post-reset edge completes normally.
